// File: rtl/decoder_sched_pkg.sv
// Shared types and constants for the shared-decoder round-robin scheduler.
package decoder_sched_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sched_state_t;

    // Idle cycles with start held low so the reset-less decoder drains.
    localparam int FLUSH_CYCLES        = 2;
    // Cycles from dec_start to data_ready for a healthy decoder.
    localparam int DEC_NOMINAL_LATENCY = 2;

    // Width of a round-robin pointer over num_req requesters.
    function automatic int rr_ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request after i_ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Walk from the farthest candidate to the nearest so the nearest one
    // after the pointer overwrites every earlier hit.
    always_comb begin
        int          w_j;
        logic [N-1:0] w_sh;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_sh    = '0;
        for (int k = N; k >= 1; k--) begin
            w_j  = (int'(i_ptr) + k) % N;
            w_sh = i_req >> w_j;
            if (w_sh[0]) begin
                o_grant = N'(1) << w_j;
                o_idx   = PW'(w_j);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_rr_scheduler.sv
// Time-shares one code-to-float decoder among NUM_REQ requesters, one decode
// in flight, with a timeout that returns an error and re-flushes the decoder.
module decoder_rr_scheduler
    import decoder_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CODE_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*CODE_WIDTH-1:0]  i_req_code,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [NUM_REQ-1:0]             o_resp_valid,
    output logic [DATA_WIDTH-1:0]          o_resp_data,
    output logic                           o_resp_err,
    output logic                           o_dec_start,
    output logic [CODE_WIDTH-1:0]          o_dec_code,
    input  logic                           i_dec_ready,
    input  logic [DATA_WIDTH-1:0]          i_dec_value,
    output logic                           o_busy
);

    localparam int PW  = rr_ptr_width(NUM_REQ);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    sched_state_t          r_state;
    logic [FCW-1:0]        r_flush_cnt;
    logic [WCW-1:0]        r_wait_cnt;
    logic [PW-1:0]         r_ptr;
    logic [NUM_REQ-1:0]    r_gnt;
    logic                  r_flush_pend;
    logic                  r_dec_start;
    logic [CODE_WIDTH-1:0] r_dec_code;
    logic [NUM_REQ-1:0]    r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_err;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PW-1:0]         w_idx;
    logic                  w_any;
    logic [CODE_WIDTH-1:0] w_code;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_code       = CODE_WIDTH'(i_req_code >> (w_idx * CODE_WIDTH));
    assign o_req_ready  = (r_state == IDLE) ? w_grant : '0;
    assign o_busy       = (r_state != IDLE);
    assign o_dec_start  = r_dec_start;
    assign o_dec_code   = r_dec_code;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;

    // Scheduler FSM: flush, accept, issue, wait for result or timeout, respond.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= INIT;
            r_flush_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_ptr        <= PW'(NUM_REQ - 1);
            r_gnt        <= '0;
            r_flush_pend <= 1'b0;
            r_dec_start  <= 1'b0;
            r_dec_code   <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_dec_start  <= 1'b0;
            r_resp_valid <= '0;
            case (r_state)
                INIT: begin
                    if (r_flush_cnt == FCW'(FLUSH_CYCLES - 1)) begin
                        r_flush_cnt <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_grant;
                        r_ptr       <= w_idx;
                        r_dec_code  <= w_code;
                        r_dec_start <= 1'b1;
                        r_resp_err  <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (i_dec_ready) begin
                        r_resp_data  <= i_dec_value;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= r_gnt;
                        r_state      <= RESP;
                    end else if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= r_gnt;
                        r_flush_pend <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state      <= r_flush_pend ? INIT : IDLE;
                    r_flush_pend <= 1'b0;
                    r_flush_cnt  <= '0;
                end
                default: r_state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Self-checking bench: vector table, hand-written corner sequences, and a
// randomized run scored against a transaction-level reference model.
module tb_decoder_rr_scheduler;
    import decoder_sched_pkg::*;

    localparam int NR   = 4;
    localparam int CW   = 8;
    localparam int TO   = 8;
    localparam int NOM  = DEC_NOMINAL_LATENCY;
    localparam int DEAD = 255;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*CW-1:0]  req_code;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              dec_start;
    logic [CW-1:0]     dec_code;
    logic              dec_ready;
    logic [31:0]       dec_value;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;

    int        cur_lat = NOM;
    bit        spur    = 1'b0;
    int        dec_cd  = 0;
    logic [7:0] dec_lc = '0;

    decoder_rr_scheduler #(.NUM_REQ(NR), .CODE_WIDTH(CW), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .i_clock(clock), .i_reset(reset),
        .i_req_valid(req_valid), .i_req_code(req_code), .o_req_ready(req_ready),
        .o_resp_valid(resp_valid), .o_resp_data(resp_data), .o_resp_err(resp_err),
        .o_dec_start(dec_start), .o_dec_code(dec_code),
        .i_dec_ready(dec_ready), .i_dec_value(dec_value), .o_busy(busy)
    );

    always #5 clock = ~clock;

    // Stand-in for the shared decoder: looks only at the low 6 code bits.
    function automatic logic [31:0] dec_fn(input logic [7:0] c);
        case (c[5:0])
            6'd0:    return 32'h3F80_0000;
            6'd1:    return 32'h4000_0000;
            6'd2:    return 32'h4040_0000;
            6'd3:    return 32'h4080_0000;
            6'd4:    return 32'h40C0_0000;
            6'd10:   return 32'h0000_0000;
            6'd12:   return 32'h4280_0000;
            default: return 32'h4100_0000 | {26'd0, c[5:0]};
        endcase
    endfunction

    // Decoder model: answers cur_lat cycles after start; DEAD never answers.
    initial begin
        dec_ready = 1'b0;
        dec_value = '0;
        forever begin
            @(posedge clock); #1;
            dec_ready = 1'b0;
            dec_value = $urandom;
            if (reset) begin
                dec_cd = 0;
            end else begin
                if (dec_cd > 0) begin
                    dec_cd--;
                    if (dec_cd == 0) begin
                        dec_ready = 1'b1;
                        dec_value = dec_fn(dec_lc);
                    end
                end
                if (dec_start && cur_lat != DEAD) begin
                    dec_lc = dec_code;
                    dec_cd = cur_lat;
                end
                if (spur) begin
                    dec_ready = 1'b1;
                    dec_value = 32'hDEAD_BEEF;
                    spur      = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Leaves the bench #1 after the edge, in the first INIT cycle (cycle 0).
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        cur_lat   = NOM;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        int          req;
        logic [7:0]  code;
        int          lat;
        logic [31:0] data;
        logic        err;
        int          dly;
    } vec_t;

    vec_t vt[8];

    // Randomized traffic scored against a transaction-level model.
    task automatic run_random(input int ncyc);
        int          free_at, ptr, g, lat, scyc, rcyc, ridx;
        bit          pend[NR];
        logic [7:0]  pcode[NR];
        logic [7:0]  scode;
        logic [31:0] rdata;
        logic        rerr;
        logic [NR-1:0] exp_rdy, exp_rv;
        bit          exp_busy;
        do_reset();
        ptr = NR - 1; free_at = FLUSH_CYCLES; scyc = -1; rcyc = -1; ridx = 0;
        scode = '0; rdata = '0; rerr = 1'b0;
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pcode[i] = '0; end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[i]  = 1'b1;
                        pcode[i] = 8'($urandom_range(0, 255));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i]        = pend[i];
                req_code[i*CW +: CW] = pcode[i];
            end
            @(negedge clock);
            exp_busy = (cyc < free_at);
            exp_rdy  = '0;
            if (!exp_busy) begin
                g = -1;
                for (int k = 1; k <= NR; k++)
                    if (g < 0 && pend[(ptr + k) % NR]) g = (ptr + k) % NR;
                if (g >= 0) begin
                    exp_rdy = NR'(1) << g;
                    ptr     = g;
                    case ($urandom_range(0, 8))
                        0:       lat = 1;
                        1, 2, 3: lat = NOM;
                        4:       lat = 3;
                        5:       lat = 5;
                        6:       lat = TO;
                        7:       lat = TO + 1;
                        default: lat = DEAD;
                    endcase
                    cur_lat = lat;
                    scyc    = cyc + 1;
                    scode   = pcode[g];
                    ridx    = g;
                    if (lat <= TO) begin
                        rcyc = cyc + 2 + lat; rdata = dec_fn(pcode[g]); rerr = 1'b0;
                        free_at = cyc + 3 + lat;
                    end else begin
                        rcyc = cyc + TO + 2; rdata = '0; rerr = 1'b1;
                        free_at = cyc + TO + 2 + 1 + FLUSH_CYCLES;
                    end
                    pend[g] = 1'b0;
                end
            end
            chk("rnd_busy", 32'(busy), 32'(exp_busy));
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_start", 32'(dec_start), 32'(cyc == scyc));
            if (cyc == scyc) chk("rnd_code", 32'(dec_code), 32'(scode));
            exp_rv = (cyc == rcyc) ? (NR'(1) << ridx) : '0;
            chk("rnd_resp", 32'(resp_valid), 32'(exp_rv));
            if (cyc == rcyc) begin
                chk("rnd_data", resp_data, rdata);
                chk("rnd_err", 32'(resp_err), 32'(rerr));
            end
            tick();
        end
        req_valid = '0;
    endtask

    initial begin
        int r, n, dly, k;
        logic [NR-1:0] exp_rdy, exp_rv;
        logic [31:0]   seqa_data[4];

        vt[0] = '{0, 8'h00, NOM,  32'h3F80_0000, 1'b0, 4};
        vt[1] = '{1, 8'h0A, NOM,  32'h0000_0000, 1'b0, 4};
        vt[2] = '{2, 8'hCC, NOM,  32'h4280_0000, 1'b0, 4};
        vt[3] = '{3, 8'h03, 1,    32'h4080_0000, 1'b0, 3};
        vt[4] = '{0, 8'h02, TO,   32'h4040_0000, 1'b0, TO + 2};
        vt[5] = '{1, 8'h04, DEAD, 32'h0000_0000, 1'b1, TO + 2};
        vt[6] = '{2, 8'h01, 3,    32'h4000_0000, 1'b0, 5};
        vt[7] = '{3, 8'h41, NOM,  32'h4000_0000, 1'b0, 4};
        seqa_data[0] = 32'h4000_0000; seqa_data[1] = 32'h4040_0000;
        seqa_data[2] = 32'h4080_0000; seqa_data[3] = 32'h40C0_0000;

        // Reset state
        reset = 1'b1; req_valid = '0; req_code = '0;
        @(negedge clock);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_dec_start", 32'(dec_start), 0);
        chk("rst_dec_code", 32'(dec_code), 0);

        // INIT flush after release, then the vector table
        do_reset();
        req_valid = 4'b0001;
        req_code  = '0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clock);
            chk("init_busy", 32'(busy), 1);
            chk("init_start", 32'(dec_start), 0);
            chk("init_ready", 32'(req_ready), 0);
            tick();
        end
        req_valid = '0;
        for (int v = 0; v < 8; v++) begin
            r = vt[v].req;
            req_code[r*CW +: CW] = vt[v].code;
            req_valid = NR'(1) << r;
            cur_lat   = vt[v].lat;
            n = 0;
            @(negedge clock);
            while (req_ready == '0 && n < 30) begin tick(); @(negedge clock); n++; end
            chk("tbl_accept", 32'(req_ready), 32'(NR'(1) << r));
            tick();
            req_valid = '0;
            @(negedge clock);
            chk("tbl_start", 32'(dec_start), 1);
            chk("tbl_code", 32'(dec_code), 32'(vt[v].code));
            dly = 1;
            while (resp_valid == '0 && dly < 40) begin tick(); @(negedge clock); dly++; end
            chk("tbl_latency", dly, vt[v].dly);
            chk("tbl_resp", 32'(resp_valid), 32'(NR'(1) << r));
            chk("tbl_data", resp_data, vt[v].data);
            chk("tbl_err", 32'(resp_err), 32'(vt[v].err));
            tick();
        end

        // All requesters held: grants 0,1,2,3,0 every 5 cycles
        do_reset();
        for (int i = 0; i < NR; i++) req_code[i*CW +: CW] = 8'(i + 1);
        req_valid = '1;
        for (int cyc = 0; cyc < 27; cyc++) begin
            @(negedge clock);
            exp_rdy = '0;
            if (cyc >= 2 && (cyc - 2) % 5 == 0) exp_rdy = NR'(1) << (((cyc - 2) / 5) % NR);
            chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
            exp_rv = '0;
            if (cyc >= 6 && (cyc - 6) % 5 == 0) begin
                k = ((cyc - 6) / 5) % NR;
                exp_rv = NR'(1) << k;
                chk("rr_data", resp_data, seqa_data[k]);
                chk("rr_err", 32'(resp_err), 0);
            end
            chk("rr_resp", 32'(resp_valid), 32'(exp_rv));
            tick();
        end
        req_valid = '0;

        // Timeout on requester 0, INIT flush, then requester 1 served
        do_reset();
        req_code = '0; req_code[7:0] = 8'd5; req_code[15:8] = 8'd3;
        req_valid = 4'b0011; cur_lat = DEAD;
        for (int cyc = 0; cyc < 21; cyc++) begin
            if (cyc == 3)  req_valid[0] = 1'b0;
            if (cyc == 5)  cur_lat = NOM;
            if (cyc == 16) req_valid[1] = 1'b0;
            @(negedge clock);
            exp_rdy = (cyc == 2) ? 4'b0001 : (cyc == 15) ? 4'b0010 : 4'b0000;
            chk("to_ready", 32'(req_ready), 32'(exp_rdy));
            chk("to_busy", 32'(busy), 32'(!(cyc == 2 || cyc == 15 || cyc == 20)));
            chk("to_start", 32'(dec_start), 32'(cyc == 3 || cyc == 16));
            exp_rv = (cyc == 12) ? 4'b0001 : (cyc == 19) ? 4'b0010 : 4'b0000;
            chk("to_resp", 32'(resp_valid), 32'(exp_rv));
            if (cyc == 12) begin
                chk("to_data", resp_data, 0);
                chk("to_err", 32'(resp_err), 1);
            end
            if (cyc == 19) begin
                chk("after_to_data", resp_data, 32'h4080_0000);
                chk("after_to_err", 32'(resp_err), 0);
            end
            tick();
        end

        // Spurious dec_ready while idle is ignored; resp_data holds
        @(negedge clock);
        spur = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clock);
            chk("spur_resp", 32'(resp_valid), 0);
            chk("spur_busy", 32'(busy), 0);
            chk("spur_hold", resp_data, 32'h4080_0000);
        end
        tick();

        // Reset during WAIT aborts silently and restores the pointer
        req_code[7:0] = 8'd9; req_valid = 4'b0001; cur_lat = DEAD;
        @(negedge clock);
        chk("abort_accept", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_resp", 32'(resp_valid), 0);
        chk("abort_start", 32'(dec_start), 0);
        chk("abort_code", 32'(dec_code), 0);
        chk("abort_data", resp_data, 0);
        chk("abort_err", 32'(resp_err), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        req_code[7:0] = 8'd7; req_code[15:8] = 8'd8; req_valid = 4'b0011; cur_lat = NOM;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 3) req_valid[0] = 1'b0;
            if (cyc == 8) req_valid[1] = 1'b0;
            @(negedge clock);
            exp_rdy = (cyc == 2) ? 4'b0001 : (cyc == 7) ? 4'b0010 : 4'b0000;
            chk("rearm_ready", 32'(req_ready), 32'(exp_rdy));
            if (cyc < 2) chk("rearm_busy", 32'(busy), 1);
            exp_rv = (cyc == 6) ? 4'b0001 : (cyc == 11) ? 4'b0010 : 4'b0000;
            chk("rearm_resp", 32'(resp_valid), 32'(exp_rv));
            if (cyc == 6)  chk("rearm_data0", resp_data, 32'h4100_0007);
            if (cyc == 11) chk("rearm_data1", resp_data, 32'h4100_0008);
            tick();
        end

        run_random(800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
